retire_queue: RTL and testbench
===============================

# retire_queue

In-order retirement buffer that generalises the single-entry ALU→ARF retire register into a DEPTH-entry circular completion queue. Dispatch allocates an entry per instruction in program order and receives a tag. CMP_PORTS execution units write results back out of order by tag. Up to RETIRE_W completed instructions at the head retire per cycle to the ARF write ports, strictly in program order, with flush and stall support.

## Interface
- DEPTH, 8: number of entries; power of two, ≥2.
- RETIRE_W, 2: retire/ARF write ports per cycle; 1..DEPTH.
- CMP_PORTS, 2: completion ports; ≥1.
- XLEN, 32: result width.
- Derived: TAG_W = $clog2(DEPTH); CNT_W = TAG_W+1; RC_W = $clog2(RETIRE_W+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_alloc_valid  in  1  allocation request from dispatch.
- o_alloc_ready  out  1  entry available; allocation occurs when valid && ready.
- i_alloc_rd  in  5  destination register of the allocating uop.
- i_alloc_writes_rd  in  1  uop writes rd.
- o_alloc_tag  out  TAG_W  tag (entry index) given to the allocating uop; equals tail index.
- i_cmp_valid  in  CMP_PORTS  per-port completion strobe.
- i_cmp_tag  in  CMP_PORTS*TAG_W  packed completion tags; port p at [p*TAG_W +: TAG_W].
- i_cmp_data  in  CMP_PORTS*XLEN  packed results.
- i_flush  in  1  discard all entries.
- i_stall  in  1  block retirement (allocation and completion continue).
- o_wb_en  out  RETIRE_W  per-slot ARF write enable.
- o_wb_rd  out  RETIRE_W*5  per-slot destination.
- o_wb_data  out  RETIRE_W*XLEN  per-slot data.
- o_retire_cnt  out  RC_W  entries retired this cycle (including non-writing uops).
- o_count  out  CNT_W  occupied entries.
- o_empty  out  1  o_count == 0.

## Operation
- State: per entry {valid, done, writes_rd, rd, data}. Head and tail pointers are CNT_W wide (extra wrap bit). count = tail − head; full when count == DEPTH.
- o_alloc_ready = !full && !i_flush. It depends on registered state only, with no pass-through of same-cycle retirement.
- Allocate: the tail entry is set to valid=1, done=0, with rd and writes_rd captured. The tail increments and wraps modulo 2·DEPTH.
- Complete: for each port with valid set, if the addressed entry is valid and not done, set done=1 and write data.
  - Completion to an invalid or already-done entry is ignored.
  - If two ports target the same tag in the same cycle, the lowest-index port wins.
- Retire selection (combinational from registered state): slot k (k = 0..RETIRE_W−1) holds entry head+k. The slot is eligible if that entry is valid and done and slots 0..k−1 are eligible; retirement stops at the first non-done entry.
  - If i_stall or i_flush is high, no slot is eligible.
- Retire outputs per eligible slot k:
  - o_wb_en[k] = writes_rd && rd != 0.
  - o_wb_rd[k] = rd; o_wb_data[k] = data.
  - Ineligible slots drive en=0, rd=0, data=0.
- Retire update: at the edge, retired entries have valid cleared, and head advances by o_retire_cnt.
- Slot order is program order. A bench or ARF applies slot k after slot k−1 when rd matches (later slot wins).
- Allocation, completion and retirement may all occur in the same cycle, on different entries.
- Flush: at the edge where i_flush=1, all valid and done bits clear and head = tail = 0. The same-cycle allocation and completions are dropped. No writeback occurs in the flush cycle.
- Reset (rst_n=0 at edge): identical to flush, plus data, rd and writes_rd cleared to 0. Reset mid-operation discards everything.

## Timing
- After reset, every output is 0 except: o_alloc_ready=1 (if i_flush=0) and o_empty=1. o_alloc_tag=0.
- Allocate at edge N; the earliest accepted completion is in the cycle after edge N (a completion to the tag being allocated in the same cycle is ignored).
- Complete at edge M; the earliest retirement is the cycle after edge M (no completion-to-retire bypass). Minimum alloc→retire is 2 edges.
- The full→ready transition is visible the cycle after the retiring edge.
- Throughput: 1 allocation/cycle, CMP_PORTS completions/cycle, RETIRE_W retirements/cycle.
- Wrap: tags wrap DEPTH−1 → 0 and pointers carry the wrap bit. full and empty are distinguished solely by the wrap bit.

## Test plan
- Reset/basic: allocate 3 uops (rd=5,6,7), complete tag 0 with 0xA, tag 1 with 0xB → next cycle o_wb_en=2'b11, rd 5,6, data 0xA,0xB, o_retire_cnt=2. Tag 2 is not retired until it completes.
- Out-of-order: complete tag 2 before tag 0 → no retirement until tag 0 is done. Then tags 0 and 1 retire in order, and tag 2 retires on the following cycle if tag 1 was done.
- Full/wrap: allocate 8 without completing → o_alloc_ready=0, o_count=8. Complete all, retire 2/cycle → tags reuse 0.. after the wrap, o_empty=1 after 4 retire cycles.
- Stall and rd=x0/no-write: i_stall=1 with done head → o_wb_en=0, o_retire_cnt=0. Release the stall → entries retire; an entry with rd=0 or writes_rd=0 retires with en=0 and is counted.
- Completion collisions: two ports complete the same tag with 0x1 and 0x2 → data 0x1 retires. A completion to a free tag is ignored (o_count unchanged, no retirement).
- Flush mid-operation: 5 entries, 2 done, i_flush=1 with simultaneous alloc → o_wb_en=0 that cycle. Next cycle o_count=0, o_empty=1, o_alloc_tag=0; rst_n=0 mid-stream gives the same result.

Source files
------------

// File: rtl/retire_queue.sv
// In-order retirement buffer: DEPTH-entry circular completion queue with
// tag-addressed out-of-order completion and up to RETIRE_W in-order retirements per cycle.
module retire_queue #(
  parameter int DEPTH     = 8,
  parameter int RETIRE_W  = 2,
  parameter int CMP_PORTS = 2,
  parameter int XLEN      = 32,
  localparam int TAG_W    = $clog2(DEPTH),
  localparam int CNT_W    = TAG_W + 1,
  localparam int RC_W     = $clog2(RETIRE_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_alloc_valid,
  output logic                      o_alloc_ready,
  input  logic [4:0]                i_alloc_rd,
  input  logic                      i_alloc_writes_rd,
  output logic [TAG_W-1:0]          o_alloc_tag,
  input  logic [CMP_PORTS-1:0]      i_cmp_valid,
  input  logic [CMP_PORTS*TAG_W-1:0] i_cmp_tag,
  input  logic [CMP_PORTS*XLEN-1:0] i_cmp_data,
  input  logic                      i_flush,
  input  logic                      i_stall,
  output logic [RETIRE_W-1:0]       o_wb_en,
  output logic [RETIRE_W*5-1:0]     o_wb_rd,
  output logic [RETIRE_W*XLEN-1:0]  o_wb_data,
  output logic [RC_W-1:0]           o_retire_cnt,
  output logic [CNT_W-1:0]          o_count,
  output logic                      o_empty
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q,  done_d;
  logic [DEPTH-1:0] wr_q,    wr_d;
  logic [4:0]       rd_q    [DEPTH];
  logic [4:0]       rd_d    [DEPTH];
  logic [XLEN-1:0]  data_q  [DEPTH];
  logic [XLEN-1:0]  data_d  [DEPTH];
  logic [CNT_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] tail_q, tail_d;

  logic [CNT_W-1:0]    count;
  logic                full;
  logic                alloc_fire;
  logic [TAG_W-1:0]    tail_idx;
  logic [TAG_W-1:0]    slot_idx  [RETIRE_W];
  logic [RETIRE_W-1:0] slot_elig;
  logic                chain;
  logic [RC_W-1:0]     retire_cnt;
  logic [TAG_W-1:0]    cmp_tag   [CMP_PORTS];
  logic [XLEN-1:0]     cmp_data  [CMP_PORTS];

  assign count         = tail_q - head_q;
  assign full          = (count == CNT_W'(DEPTH));
  assign tail_idx      = tail_q[TAG_W-1:0];
  assign o_alloc_ready = !full && !i_flush;
  assign alloc_fire    = i_alloc_valid && o_alloc_ready;
  assign o_alloc_tag   = tail_idx;
  assign o_count       = count;
  assign o_empty       = (count == '0);
  assign o_retire_cnt  = retire_cnt;

  always_comb begin
    for (int unsigned p = 0; p < CMP_PORTS; p++) begin
      cmp_tag[p]  = i_cmp_tag[p*TAG_W +: TAG_W];
      cmp_data[p] = i_cmp_data[p*XLEN +: XLEN];
    end
  end

  // Retirement chain: slot k only retires if every older slot also retires.
  always_comb begin
    chain      = !i_stall && !i_flush;
    retire_cnt = '0;
    slot_elig  = '0;
    o_wb_en    = '0;
    o_wb_rd    = '0;
    o_wb_data  = '0;
    for (int unsigned k = 0; k < RETIRE_W; k++) begin
      slot_idx[k]  = head_q[TAG_W-1:0] + TAG_W'(k);
      chain        = chain && valid_q[slot_idx[k]] && done_q[slot_idx[k]];
      slot_elig[k] = chain;
      if (chain) begin
        retire_cnt               = retire_cnt + 1'b1;
        o_wb_en[k]               = wr_q[slot_idx[k]] && (rd_q[slot_idx[k]] != '0);
        o_wb_rd[k*5 +: 5]        = rd_q[slot_idx[k]];
        o_wb_data[k*XLEN +: XLEN] = data_q[slot_idx[k]];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (i_flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      for (int unsigned k = 0; k < RETIRE_W; k++) begin
        if (slot_elig[k]) begin
          valid_d[slot_idx[k]] = 1'b0;
          done_d[slot_idx[k]]  = 1'b0;
        end
      end
      head_d = head_q + CNT_W'(retire_cnt);
      // Ports are applied highest-first so the lowest-index port's write lands last.
      for (int unsigned q = 0; q < CMP_PORTS; q++) begin
        if (i_cmp_valid[CMP_PORTS-1-q] && valid_q[cmp_tag[CMP_PORTS-1-q]]
            && !done_q[cmp_tag[CMP_PORTS-1-q]]) begin
          done_d[cmp_tag[CMP_PORTS-1-q]] = 1'b1;
          data_d[cmp_tag[CMP_PORTS-1-q]] = cmp_data[CMP_PORTS-1-q];
        end
      end
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        wr_d[tail_idx]    = i_alloc_writes_rd;
        rd_d[tail_idx]    = i_alloc_rd;
        tail_d            = tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      wr_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_retire_queue.sv
// Directed, table-driven bench for retire_queue (DEPTH=8, RETIRE_W=2, CMP_PORTS=2, XLEN=32).
module tb_retire_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_alloc_valid = 1'b0;
  logic        o_alloc_ready;
  logic [4:0]  i_alloc_rd = '0;
  logic        i_alloc_writes_rd = 1'b0;
  logic [2:0]  o_alloc_tag;
  logic [1:0]  i_cmp_valid = '0;
  logic [5:0]  i_cmp_tag = '0;
  logic [63:0] i_cmp_data = '0;
  logic        i_flush = 1'b0;
  logic        i_stall = 1'b0;
  logic [1:0]  o_wb_en;
  logic [9:0]  o_wb_rd;
  logic [63:0] o_wb_data;
  logic [1:0]  o_retire_cnt;
  logic [3:0]  o_count;
  logic        o_empty;

  always #5 clk = ~clk;

  retire_queue #(.DEPTH(8), .RETIRE_W(2), .CMP_PORTS(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready),
    .i_alloc_rd(i_alloc_rd), .i_alloc_writes_rd(i_alloc_writes_rd),
    .o_alloc_tag(o_alloc_tag),
    .i_cmp_valid(i_cmp_valid), .i_cmp_tag(i_cmp_tag), .i_cmp_data(i_cmp_data),
    .i_flush(i_flush), .i_stall(i_stall),
    .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_retire_cnt(o_retire_cnt), .o_count(o_count), .o_empty(o_empty)
  );

  typedef struct packed {
    logic        rst_n;
    logic        av;
    logic [4:0]  rd;
    logic        wr;
    logic [1:0]  cv;
    logic [2:0]  t0;
    logic [31:0] d0;
    logic [2:0]  t1;
    logic [31:0] d1;
    logic        fl;
    logic        st;
  } in_t;

  typedef struct packed {
    logic        ready;
    logic [2:0]  tag;
    logic [1:0]  en;
    logic [4:0]  r1;
    logic [4:0]  r0;
    logic [31:0] w1;
    logic [31:0] w0;
    logic [1:0]  rc;
    logic [3:0]  cnt;
    logic        emp;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
    bit   chk;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vq[$];

  function automatic in_t mk_in(logic r, logic av, logic [4:0] rd, logic wr, logic [1:0] cv,
                                logic [2:0] t0, logic [31:0] d0, logic [2:0] t1, logic [31:0] d1,
                                logic fl, logic st);
    in_t x;
    x.rst_n = r; x.av = av; x.rd = rd; x.wr = wr; x.cv = cv;
    x.t0 = t0; x.d0 = d0; x.t1 = t1; x.d1 = d1; x.fl = fl; x.st = st;
    return x;
  endfunction

  function automatic in_t nop();
    return mk_in(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic in_t al(logic [4:0] rd, logic wr);
    return mk_in(1, 1, rd, wr, 2'b00, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t ex(logic ready, logic [2:0] tag, logic [1:0] en, logic [4:0] r0,
                              logic [31:0] w0, logic [4:0] r1, logic [31:0] w1, logic [1:0] rc,
                              logic [3:0] cnt, logic emp);
    exp_t x;
    x.ready = ready; x.tag = tag; x.en = en; x.r0 = r0; x.w0 = w0; x.r1 = r1; x.w1 = w1;
    x.rc = rc; x.cnt = cnt; x.emp = emp;
    return x;
  endfunction

  function automatic exp_t quiet(logic [2:0] tag, logic [3:0] cnt);
    return ex(1, tag, 2'b00, 0, 0, 0, 0, 0, cnt, cnt == 4'd0);
  endfunction

  function automatic vec_t mk(in_t i, exp_t e, bit chk);
    vec_t v;
    v.i = i; v.e = e; v.chk = chk;
    return v;
  endfunction

  task automatic run(input in_t i, input exp_t e, input bit chk, input string nm);
    exp_t act;
    @(negedge clk);
    rst_n             = i.rst_n;
    i_alloc_valid     = i.av;
    i_alloc_rd        = i.rd;
    i_alloc_writes_rd = i.wr;
    i_cmp_valid       = i.cv;
    i_cmp_tag         = {i.t1, i.t0};
    i_cmp_data        = {i.d1, i.d0};
    i_flush           = i.fl;
    i_stall           = i.st;
    #2;
    act = {o_alloc_ready, o_alloc_tag, o_wb_en, o_wb_rd, o_wb_data, o_retire_cnt, o_count, o_empty};
    if (chk) begin
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got ready=%b tag=%0d en=%b rd=%h data=%h rc=%0d cnt=%0d empty=%b ; expected ready=%b tag=%0d en=%b rd=%h data=%h rc=%0d cnt=%0d empty=%b",
                 nm, act.ready, act.tag, act.en, {act.r1, act.r0}, {act.w1, act.w0}, act.rc, act.cnt, act.emp,
                 e.ready, e.tag, e.en, {e.r1, e.r0}, {e.w1, e.w0}, e.rc, e.cnt, e.emp);
      end
    end
  endtask

  initial begin
    // reset, basic in-order retire, tag 2 waits for its completion
    vq.push_back(mk(mk_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), '0, 0));
    vq.push_back(mk(nop(), quiet(0, 0), 1));
    vq.push_back(mk(al(5, 1), quiet(0, 0), 1));
    vq.push_back(mk(al(6, 1), quiet(1, 1), 1));
    vq.push_back(mk(mk_in(1, 1, 7, 1, 2'b11, 0, 32'hA, 1, 32'hB, 0, 0), quiet(2, 2), 1));
    vq.push_back(mk(nop(), ex(1, 3, 2'b11, 5, 32'hA, 6, 32'hB, 2, 3, 0), 1));
    vq.push_back(mk(nop(), quiet(3, 1), 1));
    vq.push_back(mk(mk_in(1, 0, 0, 0, 2'b01, 2, 32'hC, 0, 0, 0, 0), quiet(3, 1), 1));
    vq.push_back(mk(nop(), ex(1, 3, 2'b01, 7, 32'hC, 0, 0, 1, 1, 0), 1));
    vq.push_back(mk(nop(), quiet(3, 0), 1));
    // out-of-order completion; completion to the tag being allocated is dropped
    vq.push_back(mk(al(1, 1), quiet(3, 0), 1));
    vq.push_back(mk(al(2, 1), quiet(4, 1), 1));
    vq.push_back(mk(mk_in(1, 1, 3, 1, 2'b01, 5, 32'h55, 0, 0, 0, 0), quiet(5, 2), 1));
    vq.push_back(mk(mk_in(1, 0, 0, 0, 2'b10, 0, 0, 5, 32'h33, 0, 0), quiet(6, 3), 1));
    vq.push_back(mk(mk_in(1, 0, 0, 0, 2'b01, 3, 32'h11, 0, 0, 0, 0), quiet(6, 3), 1));
    vq.push_back(mk(mk_in(1, 0, 0, 0, 2'b01, 4, 32'h22, 0, 0, 0, 0),
                    ex(1, 6, 2'b01, 1, 32'h11, 0, 0, 1, 3, 0), 1));
    vq.push_back(mk(nop(), ex(1, 6, 2'b11, 2, 32'h22, 3, 32'h33, 2, 2, 0), 1));
    vq.push_back(mk(nop(), quiet(6, 0), 1));
    // stall, rd=x0 and writes_rd=0 retire silently; tag wraps 7 -> 0
    vq.push_back(mk(al(0, 1), quiet(6, 0), 1));
    vq.push_back(mk(al(9, 0), quiet(7, 1), 1));
    vq.push_back(mk(mk_in(1, 1, 10, 1, 2'b11, 6, 32'h66, 7, 32'h77, 0, 0), quiet(0, 2), 1));
    vq.push_back(mk(mk_in(1, 0, 0, 0, 2'b01, 0, 32'hA0, 0, 0, 0, 1), quiet(1, 3), 1));
    vq.push_back(mk(mk_in(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1), quiet(1, 3), 1));
    vq.push_back(mk(nop(), ex(1, 1, 2'b00, 0, 32'h66, 9, 32'h77, 2, 3, 0), 1));
    vq.push_back(mk(nop(), ex(1, 1, 2'b01, 10, 32'hA0, 0, 0, 1, 1, 0), 1));
    vq.push_back(mk(nop(), quiet(1, 0), 1));
    // same-tag collision (port 0 wins) and completions to free entries
    vq.push_back(mk(al(12, 1), quiet(1, 0), 1));
    vq.push_back(mk(mk_in(1, 0, 0, 0, 2'b11, 1, 32'h1, 1, 32'h2, 0, 0), quiet(2, 1), 1));
    vq.push_back(mk(nop(), ex(1, 2, 2'b01, 12, 32'h1, 0, 0, 1, 1, 0), 1));
    vq.push_back(mk(mk_in(1, 0, 0, 0, 2'b11, 3, 32'h99, 2, 32'h98, 0, 0), quiet(2, 0), 1));
    vq.push_back(mk(al(13, 1), quiet(2, 0), 1));
    vq.push_back(mk(nop(), quiet(3, 1), 1));
    vq.push_back(mk(mk_in(1, 0, 0, 0, 2'b10, 0, 0, 2, 32'h5, 0, 0), quiet(3, 1), 1));
    vq.push_back(mk(nop(), ex(1, 3, 2'b01, 13, 32'h5, 0, 0, 1, 1, 0), 1));
    // flush with 5 entries (2 done, head pending) and a simultaneous alloc
    vq.push_back(mk(al(1, 1), quiet(3, 0), 1));
    vq.push_back(mk(al(2, 1), quiet(4, 1), 1));
    vq.push_back(mk(mk_in(1, 1, 3, 1, 2'b01, 4, 32'h2, 0, 0, 0, 0), quiet(5, 2), 1));
    vq.push_back(mk(mk_in(1, 1, 4, 1, 2'b01, 5, 32'h3, 0, 0, 0, 0), quiet(6, 3), 1));
    vq.push_back(mk(al(5, 1), quiet(7, 4), 1));
    vq.push_back(mk(mk_in(1, 1, 6, 1, 2'b01, 3, 32'hF, 0, 0, 1, 0),
                    ex(0, 0, 2'b00, 0, 0, 0, 0, 0, 5, 0), 1));
    vq.push_back(mk(nop(), quiet(0, 0), 1));
    vq.push_back(mk(al(8, 1), quiet(0, 0), 1));
    vq.push_back(mk(nop(), quiet(1, 1), 1));

    foreach (vq[n]) run(vq[n].i, vq[n].e, vq[n].chk, $sformatf("vec%0d", n));

    // reset mid-stream with a done head entry and a concurrent alloc
    run(mk_in(1, 0, 0, 0, 2'b01, 0, 32'h44, 0, 0, 0, 0), quiet(1, 1), 1, "rst_cmp");
    run(mk_in(0, 1, 3, 1, 2'b01, 1, 32'h45, 0, 0, 0, 0), '0, 0, "rst_assert");
    run(nop(), quiet(0, 0), 1, "rst_after");
    run(nop(), quiet(0, 0), 1, "rst_idle");

    // fill to full, reject alloc, drain 2 per cycle, reuse tag 0
    for (int i = 0; i < 8; i++)
      run(al(5'(16 + i), 1), quiet(3'(i), 4'(i)), 1, $sformatf("fill%0d", i));
    run(al(31, 1), ex(0, 0, 2'b00, 0, 0, 0, 0, 0, 8, 0), 1, "full");
    for (int c = 0; c < 4; c++) begin
      exp_t e;
      int p;
      p = 2 * (c - 1);
      if (c == 0) e = ex(0, 0, 2'b00, 0, 0, 0, 0, 0, 8, 0);
      else e = ex((c >= 2), 0, 2'b11, 5'(16 + p), 32'(256 + p), 5'(17 + p), 32'(257 + p), 2,
                  4'(8 - 2 * (c - 1)), 0);
      run(mk_in(1, 0, 0, 0, 2'b11, 3'(2 * c), 32'(256 + 2 * c), 3'(2 * c + 1), 32'(257 + 2 * c), 0, 0),
          e, 1, $sformatf("drain%0d", c));
    end
    run(nop(), ex(1, 0, 2'b11, 22, 32'h106, 23, 32'h107, 2, 2, 0), 1, "drain4");
    run(nop(), quiet(0, 0), 1, "drained");
    run(al(20, 1), quiet(0, 0), 1, "reuse0");
    run(nop(), quiet(1, 1), 1, "reuse1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
